// File: rtl/dsp48a1_mac_sequencer.sv
// Streams operand pairs into one DSP48A1 slice as a multiply-accumulate and returns the 48-bit sum.
// Optional pre-adder path (a*(d+b)) is enabled by defining MAC_SEQ_PREADD_EN.
module dsp48a1_mac_sequencer #(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned OPM_DLY   = 2,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [47:0]      result,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
`ifdef MAC_SEQ_PREADD_EN
  input  logic [17:0]      in_d,
  output logic [17:0]      dsp_D,
`endif
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_P
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYC + 1);
  localparam int unsigned CntW   = (LEN_W > DrainW) ? LEN_W : DrainW;

`ifdef MAC_SEQ_PREADD_EN
  localparam logic [7:0] OpmFirst = 8'h11;
  localparam logic [7:0] OpmAcc   = 8'h19;
`else
  localparam logic [7:0] OpmFirst = 8'h01;
  localparam logic [7:0] OpmAcc   = 8'h09;
`endif
  localparam logic [7:0] OpmHold  = 8'h08;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StCapt} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            first_q;
  logic            busy_q, done_q, in_ready_q, dsp_rst_q;
  logic [47:0]     result_q;
  logic [7:0]      dly_q [OPM_DLY];
  logic            xfer;
  logic [7:0]      push_code;

  always_comb begin
    xfer      = (state_q == StAccum) && in_valid;
    dsp_ce    = xfer || (state_q == StDrain);
    push_code = (state_q == StDrain) ? OpmHold : (first_q ? OpmFirst : OpmAcc);
  end

  assign dsp_A      = (state_q == StAccum) ? in_a : 18'd0;
  assign dsp_B      = (state_q == StAccum) ? in_b : 18'd0;
`ifdef MAC_SEQ_PREADD_EN
  assign dsp_D      = (state_q == StAccum) ? in_d : 18'd0;
`endif
  assign dsp_OPMODE = dly_q[OPM_DLY-1];
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign in_ready   = in_ready_q;
  assign dsp_rst    = dsp_rst_q;

  // OPMODE trails the operands by OPM_DLY ce cycles so it meets its product at the P stage;
  // shifting only on ce keeps it aligned with the slice pipeline through stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(OPM_DLY); i++) dly_q[i] <= 8'h00;
    end else if (state_q == StIdle) begin
      for (int i = 0; i < int'(OPM_DLY); i++) dly_q[i] <= 8'h00;
    end else if (dsp_ce) begin
      dly_q[0] <= push_code;
      for (int i = 1; i < int'(OPM_DLY); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      dsp_rst_q  <= 1'b1;
      result_q   <= 48'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len == '0) begin
              result_q <= 48'd0;
              done_q   <= 1'b1;
            end else begin
              state_q    <= StAccum;
              cnt_q      <= CntW'(len);
              first_q    <= 1'b1;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              dsp_rst_q  <= 1'b0;
            end
          end
        end
        StAccum: begin
          if (in_valid) begin
            first_q <= 1'b0;
            cnt_q   <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_q    <= StDrain;
              cnt_q      <= CntW'(DRAIN_CYC);
              in_ready_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StCapt;
        end
        StCapt: begin
          result_q  <= dsp_P;
          done_q    <= 1'b1;
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          dsp_rst_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
